// File: rtl/data_sram_bridge_pkg.sv
// Shared definitions for the data-side SRAM bridge.
// Holds the bridge FSM state encoding and the bus transfer-size codes.
package data_sram_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } bridgeState_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/data_sram_bridge_sram_size_enc.sv
// sram_size_enc: combinational mapping of the core's byte-lane enables to a
// bus transfer size and direction.
// Ports:
//   wen  in  4  byte write enables (non-zero = store; store wins)
//   ren  in  4  byte read enables  (non-zero = load)
//   size out 2  SZ_BYTE / SZ_HALF / SZ_WORD
//   wr   out 1  1 = write transfer
module sram_size_enc
   import data_sram_bridge_pkg::*;
(
   input  logic [3:0] wen,
   input  logic [3:0] ren,
   output logic [1:0] size,
   output logic       wr
);

   logic [3:0] laneMask;

   always_comb begin
      // NOTE: every output of a combinational block gets a value on every
      // path (here via the case default) so no latch is inferred.
      wr       = (wen != 4'b0000);
      laneMask = wr ? wen : ren;
      case (laneMask)
         4'b1111:                            size = SZ_WORD;
         4'b0011, 4'b1100:                   size = SZ_HALF;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SZ_BYTE;
         // Irregular lane patterns fall back to a full-word transfer.
         default:                            size = SZ_WORD;
      endcase
   end

endmodule

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: converts the core's single-cycle M-stage data-memory port
// into a req / addr_ok / data_ok SRAM-like bus transaction, stalling the
// pipeline until the access completes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_addr/cpu_wdata       M-stage address and lane-aligned write data
//   cpu_ren/cpu_wen          byte read/write enables (store wins)
//   cpu_flush                M-stage flush, blocks starting an access
//   cpu_hold                 pipeline held by another stall source
//   cpu_rdata                load data returned to the core
//   cpu_stall                memory stall to the hazard unit
//   bus_req/wr/size/addr/wdata  request channel
//   bus_addr_ok              request accepted
//   bus_data_ok/bus_rdata    read data valid / write complete
module data_sram_bridge
   import data_sram_bridge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32   // must be 32: four byte lanes
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [3:0]        cpu_ren,
   input  logic [3:0]        cpu_wen,
   input  logic              cpu_flush,
   input  logic              cpu_hold,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [DATA_W-1:0] bus_rdata
);

   bridgeState_t state, nextState;
   logic         access;
   logic [1:0]   encSize;
   logic         encWr;

   assign access = ((cpu_ren != 4'b0000) || (cpu_wen != 4'b0000)) && !cpu_flush;

   sram_size_enc uSizeEnc (
      .wen  (cpu_wen),
      .ren  (cpu_ren),
      .size (encSize),
      .wr   (encWr)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      cpu_stall = 1'b0;
      bus_req   = 1'b0;
      case (state)
         IDLE: begin
            // Stall in the same cycle the access is seen, so the core holds
            // the instruction before the request is even issued.
            if (access) begin
               nextState = REQ;
               cpu_stall = 1'b1;
            end
         end
         REQ: begin
            bus_req   = 1'b1;
            cpu_stall = 1'b1;
            if (bus_addr_ok) nextState = WAIT;
         end
         WAIT: begin
            // Flush is deliberately ignored here: bus transactions cannot be
            // cancelled once accepted.
            cpu_stall = 1'b1;
            if (bus_data_ok) nextState = DONE;
         end
         DONE: begin
            // Holding in DONE keeps the completed instruction from being
            // reissued while the pipeline is frozen by someone else.
            if (!cpu_hold) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
      if (rst) begin
         cpu_stall = 1'b0;
         bus_req   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: these registers drive ports directly, so they are reset to
      // keep the bus and the core's load path at known values.
      if (rst) begin
         bus_wr    <= 1'b0;
         bus_size  <= SZ_BYTE;
         bus_addr  <= '0;
         bus_wdata <= '0;
         cpu_rdata <= '0;
      end else begin
         if (state == IDLE && access) begin
            bus_wr    <= encWr;
            bus_size  <= encSize;
            bus_addr  <= cpu_addr;
            bus_wdata <= cpu_wdata;
         end
         // Writes complete without data; the last load value is kept.
         if (state == WAIT && bus_data_ok && !bus_wr) begin
            cpu_rdata <= bus_rdata;
         end
      end
   end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge: table of transactions driven
// through a small bus responder, requests scored against a queue, plus
// hand-written flush and reset corner cases.
module tb_data_sram_bridge;

   logic        clk;
   logic        rst;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_ren;
   logic [3:0]  cpu_wen;
   logic        cpu_flush;
   logic        cpu_hold;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;

   data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_ren     (cpu_ren),
      .cpu_wen     (cpu_wen),
      .cpu_flush   (cpu_flush),
      .cpu_hold    (cpu_hold),
      .cpu_rdata   (cpu_rdata),
      .cpu_stall   (cpu_stall),
      .bus_req     (bus_req),
      .bus_wr      (bus_wr),
      .bus_size    (bus_size),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_addr_ok (bus_addr_ok),
      .bus_data_ok (bus_data_ok),
      .bus_rdata   (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  ren;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          addrDelay;   // REQ cycles before the one carrying addr_ok
      int          dataDelay;   // WAIT cycles before the one carrying data_ok
      int          holdCycles;  // cycles cpu_hold kept high after completion
      bit          flushWait;   // raise cpu_flush during WAIT
      logic [1:0]  expSize;
      logic        expWr;
      int          expStall;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        wr;
   } reqExp_t;

   localparam int NVEC = 9;
   vec_t        vecs [NVEC];
   reqExp_t     sbQ [$];
   int          compared;
   int          mismatched;
   logic [31:0] modelRdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      compared++;
      if (act !== want) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, want);
      end
   endtask

   task automatic busIdle();
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = 32'hBADBAD00;
   endtask

   // Pop the expected request and compare it with what the DUT presents.
   task automatic scoreRequest();
      reqExp_t e;
      if (sbQ.size() == 0) begin
         compared++;
         mismatched++;
         $display("FAIL sb_underflow: got request at %h, expected none", bus_addr);
      end else begin
         e = sbQ.pop_front();
         check("bus_addr",  bus_addr,           e.addr);
         check("bus_wdata", bus_wdata,          e.wdata);
         check("bus_size",  {30'd0, bus_size},  {30'd0, e.size});
         check("bus_wr",    {31'd0, bus_wr},    {31'd0, e.wr});
      end
   endtask

   task automatic runVec(input vec_t v);
      reqExp_t e;
      int      stallCycles;
      int      reqCycles;
      int      waitCycles;
      int      phase;   // 0 = before acceptance, 1 = waiting for data
      bit      finished;
      @(negedge clk);
      busIdle();
      cpu_ren   = v.ren;
      cpu_wen   = v.wen;
      cpu_addr  = v.addr;
      cpu_wdata = v.wdata;
      cpu_flush = 1'b0;
      cpu_hold  = 1'b0;
      e.addr = v.addr; e.wdata = v.wdata; e.size = v.expSize; e.wr = v.expWr;
      sbQ.push_back(e);
      stallCycles = 0; reqCycles = 0; waitCycles = 0; phase = 0; finished = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (cyc != 0) begin
            @(negedge clk);
            busIdle();
         end
         #1;
         if (!cpu_stall) begin
            finished = 1;
            break;
         end
         stallCycles++;
         if (cyc == 0) check("idle_cycle_req", {31'd0, bus_req}, 32'd0);
         if (phase == 0 && bus_req) begin
            reqCycles++;
            if (reqCycles == v.addrDelay + 1) begin
               bus_addr_ok = 1'b1;
               scoreRequest();
               phase = 1;
            end
         end else if (phase == 1) begin
            if (v.flushWait) cpu_flush = 1'b1;
            waitCycles++;
            if (waitCycles == v.dataDelay + 1) begin
               bus_data_ok = 1'b1;
               bus_rdata   = v.rdata;
            end
         end
      end
      if (!finished) begin
         compared++;
         mismatched++;
         $display("FAIL timeout: got stall still high, expected completion");
      end
      // DONE cycle
      if (!v.expWr) modelRdata = v.rdata;
      check("stall_cycles", stallCycles, v.expStall);
      check("cpu_rdata",    cpu_rdata,   modelRdata);
      check("done_req",     {31'd0, bus_req}, 32'd0);
      cpu_hold  = (v.holdCycles > 0);
      cpu_ren   = 4'b0000;
      cpu_wen   = 4'b0000;
      cpu_flush = 1'b0;
      for (int h = 1; h <= v.holdCycles; h++) begin
         @(negedge clk);
         busIdle();
         cpu_hold = (h < v.holdCycles);
         #1;
         check("hold_stall", {31'd0, cpu_stall}, 32'd0);
         check("hold_req",   {31'd0, bus_req},   32'd0);
         check("hold_rdata", cpu_rdata,          modelRdata);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      modelRdata = 32'h0;

      //          ren   wen   addr          wdata         rdata         aD dD hold fl size  wr   stall
      vecs[0] = '{4'hF, 4'h0, 32'h0000_1000, 32'h0,        32'hDEADBEEF, 1, 2, 0, 0, 2'd2, 1'b0, 6};
      vecs[1] = '{4'h0, 4'h4, 32'h0000_2002, 32'h00AB0000, 32'h0,        0, 0, 0, 0, 2'd0, 1'b1, 3};
      vecs[2] = '{4'hC, 4'h0, 32'h0000_3002, 32'h0,        32'hBEEF0000, 0, 1, 4, 0, 2'd1, 1'b0, 4};
      vecs[3] = '{4'h1, 4'h0, 32'h0000_4003, 32'h0,        32'h0000005A, 0, 2, 0, 1, 2'd0, 1'b0, 5};
      vecs[4] = '{4'h0, 4'h3, 32'h0000_5000, 32'h00001234, 32'h0,        2, 0, 0, 0, 2'd1, 1'b1, 5};
      vecs[5] = '{4'hF, 4'h2, 32'h0000_6001, 32'h0000CD00, 32'h0,        0, 0, 0, 0, 2'd0, 1'b1, 3};
      vecs[6] = '{4'h7, 4'h0, 32'h0000_7000, 32'h0,        32'h01020304, 0, 0, 0, 0, 2'd2, 1'b0, 3};
      vecs[7] = '{4'hF, 4'h0, 32'h0000_0100, 32'h0,        32'h11111111, 0, 0, 0, 0, 2'd2, 1'b0, 3};
      vecs[8] = '{4'hF, 4'h0, 32'h0000_0104, 32'h0,        32'h22222222, 0, 0, 0, 0, 2'd2, 1'b0, 3};

      // Reset with a load pending: stall must stay low while rst is high.
      rst = 1'b1;
      cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_ren = 4'hF; cpu_wen = 4'h0;
      cpu_flush = 1'b0; cpu_hold = 1'b0;
      busIdle();
      repeat (2) begin
         @(negedge clk);
         #1;
         check("rst_stall", {31'd0, cpu_stall}, 32'd0);
      end
      check("rst_req",   {31'd0, bus_req},  32'd0);
      check("rst_wr",    {31'd0, bus_wr},   32'd0);
      check("rst_size",  {30'd0, bus_size}, 32'd0);
      check("rst_addr",  bus_addr,          32'd0);
      check("rst_wdata", bus_wdata,         32'd0);
      check("rst_rdata", cpu_rdata,         32'd0);
      cpu_ren = 4'h0;
      @(negedge clk);
      rst = 1'b0;

      // Table of transactions, issued back to back.
      for (int i = 0; i < NVEC; i++) runVec(vecs[i]);

      // Flushed store in IDLE never starts an access.
      repeat (3) begin
         @(negedge clk);
         busIdle();
         cpu_wen = 4'hF; cpu_flush = 1'b1; cpu_addr = 32'h0000_8000;
         #1;
         check("flush_idle_stall", {31'd0, cpu_stall}, 32'd0);
         check("flush_idle_req",   {31'd0, bus_req},   32'd0);
      end
      @(negedge clk);
      cpu_wen = 4'h0; cpu_flush = 1'b0;

      // Reset in WAIT, then a late data_ok that must be dropped.
      @(negedge clk);
      busIdle();
      cpu_ren = 4'hF; cpu_addr = 32'h0000_9000; cpu_wdata = 32'h0;
      sbQ.push_back('{32'h0000_9000, 32'h0, 2'd2, 1'b0});
      #1;
      check("rw_stall_idle", {31'd0, cpu_stall}, 32'd1);
      @(negedge clk);
      #1;
      check("rw_req", {31'd0, bus_req}, 32'd1);
      bus_addr_ok = 1'b1;
      scoreRequest();
      @(negedge clk);
      busIdle();
      cpu_ren = 4'h0;
      rst = 1'b1;
      #1;
      check("rw_stall_in_rst", {31'd0, cpu_stall}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus_data_ok = 1'b1;
      bus_rdata   = 32'h12345678;
      #1;
      check("rw_req_after",   {31'd0, bus_req},   32'd0);
      check("rw_stall_after", {31'd0, cpu_stall}, 32'd0);
      check("rw_addr_after",  bus_addr,           32'd0);
      check("rw_wr_after",    {31'd0, bus_wr},    32'd0);
      check("rw_size_after",  {30'd0, bus_size},  32'd0);
      check("rw_wdata_after", bus_wdata,          32'd0);
      check("rw_rdata_after", cpu_rdata,          32'd0);
      @(negedge clk);
      busIdle();
      #1;
      check("rw_late_rdata", cpu_rdata,          32'd0);
      check("rw_late_stall", {31'd0, cpu_stall}, 32'd0);
      check("rw_late_req",   {31'd0, bus_req},   32'd0);

      check("sb_empty", sbQ.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
